death_detector: RTL and testbench
=================================

DEATH_DETECTOR -- requirements
Module: death_detector

Interface
REQ-001 Parameter: PLAYER_W, default 16, player sprite width in pixels.
REQ-002 Parameter: OFF_FRAMES, default 3, number of consecutive off-road frames that kill the player (range 1..15).
REQ-003 Parameter: GRACE_FRAMES, default 120, respawn invulnerability length in frames (range 1..255).
REQ-004 Port: clk, input, 1, 100 MHz system clock; the block uses one clock.
REQ-005 Port: rst, input, 1, asynchronous active-high reset.
REQ-006 Port: frame_tick, input, 1, one-cycle pulse per video frame; all position sampling happens only on this pulse.
REQ-007 Port: start, input, 1, level, start-game request.
REQ-008 Port: player_x, input, 10, left edge of the player in pixels.
REQ-009 Port: road_left, input, 10, leftmost on-road pixel for the current frame.
REQ-010 Port: road_right, input, 10, rightmost on-road pixel for the current frame.
REQ-011 Port: dead, output, 1, one-cycle pulse on death; this pulse drives the timer/display death input.
REQ-012 Port: in_grace, output, 1, high while the player is invulnerable.
REQ-013 Port: playing, output, 1, high in the ALIVE and GRACE states.
REQ-014 Port: death_count, output, 8, total deaths; saturates at 255.

Function
REQ-015 The block SHALL implement an FSM with four states: IDLE, GRACE, ALIVE and DEAD.
REQ-016 Off-road on a frame SHALL be defined as: player_x < road_left, OR ({1'b0,player_x} + PLAYER_W - 1) > road_right, evaluated in 11 bits so the sum does not wrap.
REQ-017 A frame with road_left > road_right SHALL count as invalid: the block ignores it and holds the off-road counter.
REQ-018 In IDLE, start=1 SHALL move the FSM to GRACE and load the grace counter with GRACE_FRAMES on the next clock edge.
REQ-019 In GRACE, each frame_tick SHALL decrement the grace counter; the tick that brings it to 0 SHALL move the FSM to ALIVE, with the off-road counter cleared.
REQ-020 In GRACE, the block SHALL ignore the off-road condition.
REQ-021 In ALIVE, each frame_tick SHALL update the off-road counter: increment it on an off-road frame, clear it to 0 on an on-road frame.
REQ-022 In ALIVE, the frame_tick on which the off-road counter would reach OFF_FRAMES SHALL move the FSM to DEAD.
REQ-023 DEAD SHALL last exactly one cycle, during which dead=1 and death_count increments unless it is already 255.
REQ-024 On leaving DEAD, the FSM SHALL go to GRACE and reload the grace counter with GRACE_FRAMES.
REQ-025 Latency: dead SHALL assert exactly 2 clock cycles after the killing frame_tick (tick registered, then DEAD state registered).
REQ-026 The block SHALL produce exactly one dead pulse per death, regardless of how long the player stays off-road.
REQ-027 The start input SHALL be ignored in every state except IDLE.
REQ-028 The block SHALL return to IDLE only through reset.
REQ-029 dead and in_grace SHALL be decoded from registered state only, with no combinational path from any input.
REQ-030 in_grace SHALL equal 1 exactly when the state is GRACE.

Reset
REQ-031 When rst=1 the block SHALL asynchronously force: state=IDLE, dead=0, in_grace=0, playing=0, death_count=0, off-road counter=0, grace counter=0.
REQ-032 When rst asserts mid-grace or mid-death, the block SHALL abort immediately without emitting a dead pulse.
REQ-033 A reset asserted in the same cycle as dead SHALL suppress the pulse.
REQ-034 After rst deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-035 Reset, then hold start=0 for 5 frames with the player off-road -> dead never asserts, playing=0, death_count=0.
REQ-036 start=1, GRACE_FRAMES=120, player off-road throughout -> in_grace=1 for exactly 120 ticks, then ALIVE, then dead pulses 2 cycles after the 3rd off-road tick in ALIVE, death_count=1.
REQ-037 In ALIVE: off, off, on, off, off pattern (road_left=100, road_right=300, player_x alternating 50/150) -> no death; a 3rd consecutive off frame -> exactly one dead pulse.
REQ-038 Right-edge boundary, road_right=300: player_x=285 -> on-road (285+15=300); player_x=286 -> off-road. Left-edge boundary, road_left=100: player_x=99 -> off-road.
REQ-039 Invalid road (road_left=400, road_right=200) for 10 ticks in ALIVE -> no death and off-road counter unchanged.
REQ-040 Force 260 deaths -> death_count stays at 255, and dead still pulses on every death.

Source files
------------

// File: rtl/death_detector.sv
// death_detector: tracks player life state (IDLE/GRACE/ALIVE/DEAD) from
// per-frame position samples and emits one dead pulse per death.
`timescale 1ns/1ps
module death_detector #(
    parameter int PLAYER_W     = 16,
    parameter int OFF_FRAMES   = 3,
    parameter int GRACE_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] player_x,
    input  logic [9:0] road_left,
    input  logic [9:0] road_right,
    output logic       dead,
    output logic       in_grace,
    output logic       playing,
    output logic [7:0] death_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRACE = 2'd1,
        ALIVE = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam logic [3:0] OFF_N   = 4'(OFF_FRAMES);
    localparam logic [7:0] GRACE_N = 8'(GRACE_FRAMES);

    state_t      state, state_nx;
    logic [3:0]  off_cnt, off_cnt_nx;
    logic [7:0]  grace_cnt, grace_cnt_nx;
    logic [7:0]  count_nx;

    // registered frame sample: tick plus the off-road / invalid verdicts
    logic        tick_q;
    logic        off_q;
    logic        bad_q;

    // 11-bit right edge so player_x + PLAYER_W - 1 cannot wrap
    logic [10:0] right_edge;
    logic        off_now;
    logic        bad_now;

    assign right_edge = {1'b0, player_x} + 11'(PLAYER_W) - 11'd1;
    assign off_now    = (player_x < road_left) || (right_edge > {1'b0, road_right});
    assign bad_now    = road_left > road_right;

    // capture the frame verdict only on frame_tick; delay the tick one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= 1'b0;
            off_q  <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            tick_q <= frame_tick;
            if (frame_tick) begin
                off_q <= off_now;
                bad_q <= bad_now;
            end
        end
    end

    // state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            off_cnt     <= '0;
            grace_cnt   <= '0;
            death_count <= '0;
        end else begin
            state       <= state_nx;
            off_cnt     <= off_cnt_nx;
            grace_cnt   <= grace_cnt_nx;
            death_count <= count_nx;
        end
    end

    // next-state and counter updates driven by the registered frame sample
    always_comb begin
        state_nx     = state;
        off_cnt_nx   = off_cnt;
        grace_cnt_nx = grace_cnt;
        count_nx     = death_count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx     = GRACE;
                    grace_cnt_nx = GRACE_N;
                end
            end
            GRACE: begin
                if (tick_q) begin
                    if (grace_cnt <= 8'd1) begin
                        state_nx     = ALIVE;
                        grace_cnt_nx = '0;
                        off_cnt_nx   = '0;
                    end else begin
                        grace_cnt_nx = grace_cnt - 8'd1;
                    end
                end
            end
            ALIVE: begin
                // invalid road frames leave the off-road count untouched
                if (tick_q && !bad_q) begin
                    if (off_q) begin
                        if (off_cnt + 4'd1 == OFF_N) begin
                            state_nx   = DEAD;
                            off_cnt_nx = '0;
                        end else begin
                            off_cnt_nx = off_cnt + 4'd1;
                        end
                    end else begin
                        off_cnt_nx = '0;
                    end
                end
            end
            DEAD: begin
                state_nx     = GRACE;
                grace_cnt_nx = GRACE_N;
                if (death_count != '1) begin
                    count_nx = death_count + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign dead     = (state == DEAD);
    assign in_grace = (state == GRACE);
    assign playing  = (state == GRACE) || (state == ALIVE);

endmodule

// File: tb/tb_death_detector.sv
// Directed testbench for death_detector with hand-computed expectations.
`timescale 1ns/1ps
module tb_death_detector;

    localparam int GRACE = 120;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       start;
    logic [9:0] player_x;
    logic [9:0] road_left;
    logic [9:0] road_right;
    logic       dead;
    logic       in_grace;
    logic       playing;
    logic [7:0] death_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_pulses = 0;
    int unsigned n_deaths = 0;
    logic        mid;

    death_detector #(
        .PLAYER_W    (16),
        .OFF_FRAMES  (3),
        .GRACE_FRAMES(GRACE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .player_x   (player_x),
        .road_left  (road_left),
        .road_right (road_right),
        .dead       (dead),
        .in_grace   (in_grace),
        .playing    (playing),
        .death_count(death_count)
    );

    always #5 clk = ~clk;

    // count every dead pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (dead) n_pulses++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one frame: tick high for one cycle, then one idle cycle;
    // mid holds dead sampled one cycle after the tick
    task automatic tick(input logic [9:0] x, input logic [9:0] l, input logic [9:0] r,
                        output logic m);
        player_x   = x;
        road_left  = l;
        road_right = r;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        m = dead;
        @(negedge clk);
    endtask

    // killing off-road frame: dead must appear exactly 2 cycles after the tick
    task automatic kill(input string tag, input logic [9:0] x);
        logic m;
        tick(x, 10'd100, 10'd300, m);
        check({tag, "_lat1"}, m, 0);
        check({tag, "_dead"}, dead, 1);
        @(negedge clk);
        check({tag, "_pulse1"}, dead, 0);
        n_deaths++;
        check({tag, "_count"}, death_count, (n_deaths > 255) ? 255 : n_deaths);
    endtask

    task automatic grace_out();
        logic m;
        repeat (GRACE) tick(10'd150, 10'd100, 10'd300, m);
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        start      = 1'b0;
        player_x   = 10'd50;
        road_left  = 10'd100;
        road_right = 10'd300;
        repeat (3) @(negedge clk);
        check("rst_dead", dead, 0);
        check("rst_grace", in_grace, 0);
        check("rst_playing", playing, 0);
        check("rst_count", death_count, 0);
        rst = 1'b0;

        // idle with player off-road: nothing happens without start
        repeat (5) tick(10'd50, 10'd100, 10'd300, mid);
        check("idle_playing", playing, 0);
        check("idle_count", death_count, 0);
        check("idle_pulses", n_pulses, 0);

        // start -> grace for exactly GRACE ticks, off-road ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_grace", in_grace, 1);
        check("start_playing", playing, 1);
        repeat (GRACE - 1) tick(10'd50, 10'd100, 10'd300, mid);
        check("grace_last", in_grace, 1);
        check("grace_pulses", n_pulses, 0);
        tick(10'd50, 10'd100, 10'd300, mid);
        check("grace_end", in_grace, 0);
        check("alive_playing", playing, 1);
        tick(10'd50, 10'd100, 10'd300, mid);
        tick(10'd50, 10'd100, 10'd300, mid);
        check("alive_no_early", n_pulses, 0);
        kill("first", 10'd50);
        check("respawn_grace", in_grace, 1);
        check("first_pulses", n_pulses, 1);

        // start held high outside IDLE must not reload grace
        start = 1'b1;
        grace_out();
        check("alive2", in_grace, 0);
        tick(10'd50, 10'd100, 10'd300, mid);
        tick(10'd50, 10'd100, 10'd300, mid);
        tick(10'd150, 10'd100, 10'd300, mid);
        tick(10'd50, 10'd100, 10'd300, mid);
        tick(10'd50, 10'd100, 10'd300, mid);
        check("pattern_no_death", n_pulses, 1);
        kill("pattern", 10'd50);
        start = 1'b0;

        // edges: 285 on-road, 286 and 99 off-road
        grace_out();
        tick(10'd286, 10'd100, 10'd300, mid);
        tick(10'd286, 10'd100, 10'd300, mid);
        tick(10'd285, 10'd100, 10'd300, mid);
        tick(10'd286, 10'd100, 10'd300, mid);
        tick(10'd99, 10'd100, 10'd300, mid);
        check("edge_no_death", n_pulses, 2);
        kill("edge", 10'd286);

        // invalid road frames hold the off-road count at 2
        grace_out();
        tick(10'd50, 10'd100, 10'd300, mid);
        tick(10'd50, 10'd100, 10'd300, mid);
        repeat (10) tick(10'd50, 10'd400, 10'd200, mid);
        check("invalid_no_death", n_pulses, 3);
        check("invalid_playing", playing, 1);
        check("invalid_alive", in_grace, 0);
        kill("invalid", 10'd50);

        // saturation of death_count
        while (n_deaths < 260) begin
            grace_out();
            tick(10'd50, 10'd100, 10'd300, mid);
            tick(10'd50, 10'd100, 10'd300, mid);
            kill("sat", 10'd50);
            if (n_deaths == 255) check("sat_255", death_count, 255);
        end
        check("sat_final", death_count, 255);
        check("sat_pulses", n_pulses, 260);

        // reset mid-grace aborts immediately
        repeat (3) tick(10'd50, 10'd100, 10'd300, mid);
        rst = 1'b1;
        #1;
        check("abort_grace", in_grace, 0);
        check("abort_playing", playing, 0);
        check("abort_count", death_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick(10'd50, 10'd100, 10'd300, mid);
        check("post_rst_idle", playing, 0);

        // reset landing on the would-be dead cycle suppresses the pulse
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        grace_out();
        tick(10'd50, 10'd100, 10'd300, mid);
        tick(10'd50, 10'd100, 10'd300, mid);
        player_x   = 10'd50;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("suppr_dead", dead, 0);
        @(negedge clk);
        check("suppr_pulses", n_pulses, 260);
        check("suppr_count", death_count, 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
